// File: rtl/receptor_serial_pkg.sv
// Shared types for the serial receiver: FSM state encoding and counter sizing.
package receptor_serial_pkg;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_t;

  // Bits needed to index WIDTH sampled bits (WIDTH is at least 2).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/receptor_serial.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from S_IN and
// presents them on Q under a VALID/READY handshake with sticky overrun.
module receptor_serial
  import receptor_serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic             START,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic             READY,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             BUSY,
  output logic             OVERRUN
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  rx_state_t        state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sh_reg;
  logic             dir_q_reg;
  logic [WIDTH-1:0] q_reg;
  logic             valid_reg;
  logic             overrun_reg;

  logic [WIDTH-1:0] sh_next;
  logic             complete;

  // The candidate word includes the bit being sampled on this edge.
  always_comb begin
    sh_next  = dir_q_reg ? {S_IN, sh_reg[WIDTH-1:1]} : {sh_reg[WIDTH-2:0], S_IN};
    complete = (state_reg == RX_SHIFT) && ENB && (cnt_reg == LAST_BIT);
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_reg   <= RX_IDLE;
      cnt_reg     <= '0;
      sh_reg      <= '0;
      dir_q_reg   <= 1'b0;
      q_reg       <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (ENB) begin
        case (state_reg)
          RX_IDLE: begin
            if (START) begin
              state_reg <= RX_SHIFT;
              cnt_reg   <= '0;
              dir_q_reg <= DIR;
            end
          end
          RX_SHIFT: begin
            sh_reg  <= sh_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_BIT) begin
              if (START) begin
                cnt_reg   <= '0;
                dir_q_reg <= DIR;
              end else begin
                state_reg <= RX_IDLE;
              end
            end
          end
          default: state_reg <= RX_IDLE;
        endcase
      end

      // Handshake runs regardless of ENB; a consumed word may be replaced on the same edge.
      if (complete) begin
        if (!valid_reg || READY) begin
          q_reg     <= sh_next;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && READY) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign Q       = q_reg;
  assign VALID   = valid_reg;
  assign BUSY    = (state_reg == RX_SHIFT);
  assign OVERRUN = overrun_reg;

endmodule

// File: tb/tb_receptor_serial.sv
// Randomized and directed bench for receptor_serial against a word-level model.
module tb_receptor_serial;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESET_L = 1'b0;
  logic         ENB = 1'b0;
  logic         START = 1'b0;
  logic         DIR = 1'b0;
  logic         S_IN = 1'b0;
  logic         READY = 1'b0;
  logic [W-1:0] Q;
  logic         VALID;
  logic         BUSY;
  logic         OVERRUN;

  int n_checks = 0;
  int n_errors = 0;

  // Word-level model: which word is in flight and how many of its bits have gone.
  logic         m_busy;
  logic         m_dir;
  logic         m_valid;
  logic         m_ovr;
  int           m_idx;
  logic [W-1:0] m_word;
  logic [W-1:0] m_q;

  always #5 CLK = ~CLK;

  receptor_serial #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .ENB     (ENB),
    .START   (START),
    .DIR     (DIR),
    .S_IN    (S_IN),
    .READY   (READY),
    .Q       (Q),
    .VALID   (VALID),
    .BUSY    (BUSY),
    .OVERRUN (OVERRUN)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_dir   = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_idx   = 0;
    m_word  = '0;
    m_q     = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_q"}, 64'(Q), 64'(m_q));
    check({tag, "_valid"}, 64'(VALID), 64'(m_valid));
    check({tag, "_busy"}, 64'(BUSY), 64'(m_busy));
    check({tag, "_overrun"}, 64'(OVERRUN), 64'(m_ovr));
  endtask

  // One clock: S_IN comes from the transmitted word, model advances, outputs compared after the edge.
  task automatic step(input logic enb, input logic start, input logic dir,
                      input logic ready, input logic [W-1:0] nw);
    logic         sin;
    logic         done;
    logic [W-1:0] cand;
    if (m_busy) sin = m_dir ? m_word[m_idx] : m_word[W-1-m_idx];
    else        sin = 1'($urandom_range(1, 0));
    ENB = enb; START = start; DIR = dir; READY = ready; S_IN = sin;
    done = 1'b0;
    cand = m_word;
    if (enb) begin
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1; m_idx = 0; m_dir = dir; m_word = nw;
        end
      end else begin
        m_idx++;
        if (m_idx == W) begin
          done = 1'b1;
          cand = m_word;
          if (start) begin
            m_idx = 0; m_dir = dir; m_word = nw;
          end else begin
            m_busy = 1'b0;
          end
        end
      end
    end
    if (done) begin
      if (!m_valid || ready) begin
        m_q = cand; m_valid = 1'b1;
        $display("word %h accepted into Q", cand);
      end else begin
        m_ovr = 1'b1;
        $display("word %h dropped (overrun)", cand);
      end
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
    end
    @(posedge CLK);
    #1;
    check_outputs("cyc");
  endtask

  // Sends one frame; lat = edges after START until VALID first rises (-1 if it never did).
  task automatic run_frame(input logic [W-1:0] w, input logic d, input logic do_start,
                           input int gap_at, input int gap_len,
                           input logic rdy, input logic rdy_last,
                           input logic chain, input logic [W-1:0] nw, output int lat);
    int   edges;
    int   bits;
    logic enb;
    logic last;
    logic v0;
    edges = 0;
    bits  = 0;
    lat   = -1;
    v0    = VALID;
    if (do_start) step(1'b1, 1'b1, d, rdy, w);
    while (bits < W) begin
      enb  = !(edges >= gap_at && edges < gap_at + gap_len);
      last = enb && (bits == W - 1);
      step(enb, last && chain, d, last ? rdy_last : rdy, nw);
      edges++;
      if (enb) bits++;
      if (lat < 0 && !v0 && VALID) lat = edges;
    end
  endtask

  task automatic do_reset();
    #2;
    RESET_L = 1'b0;
    #1;
    model_reset();
    check("rst_q", 64'(Q), 64'(0));
    check("rst_valid", 64'(VALID), 64'(0));
    check("rst_busy", 64'(BUSY), 64'(0));
    check("rst_overrun", 64'(OVERRUN), 64'(0));
    @(negedge CLK);
    RESET_L = 1'b1;
  endtask

  initial begin
    int lat;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge CLK);
    RESET_L = 1'b1;

    // MSB-first frame, latency from START to VALID.
    run_frame(32'hDDDDDDDD, 1'b0, 1'b1, 100, 0, 1'b0, 1'b0, 1'b0, '0, lat);
    check("msb_latency", 64'(lat), 64'(32));
    check("msb_q", 64'(Q), 64'(32'hDDDDDDDD));
    check("msb_busy_low", 64'(BUSY), 64'(0));
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // LSB-first frames.
    run_frame(32'hAAAAAAAA, 1'b1, 1'b1, 100, 0, 1'b0, 1'b0, 1'b0, '0, lat);
    check("lsb_q_aa", 64'(Q), 64'(32'hAAAAAAAA));
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    run_frame(32'h66666666, 1'b1, 1'b1, 100, 0, 1'b0, 1'b0, 1'b0, '0, lat);
    check("lsb_q_66", 64'(Q), 64'(32'h66666666));
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);

    // ENB low for 5 cycles mid-frame stretches latency without extra bits.
    run_frame(32'h12345678, 1'b0, 1'b1, 10, 5, 1'b0, 1'b0, 1'b0, '0, lat);
    check("gap_latency", 64'(lat), 64'(37));
    check("gap_q", 64'(Q), 64'(32'h12345678));
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);

    // Chained frames with READY low: second word dropped, overrun sticks.
    run_frame(32'h11111111, 1'b0, 1'b1, 100, 0, 1'b0, 1'b0, 1'b1, 32'h22222222, lat);
    run_frame(32'h22222222, 1'b0, 1'b0, 100, 0, 1'b0, 1'b0, 1'b0, '0, lat);
    check("ovr_q", 64'(Q), 64'(32'h11111111));
    check("ovr_flag", 64'(OVERRUN), 64'(1));
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    check("ovr_valid_drop", 64'(VALID), 64'(0));

    // READY pulsed on the completion edge of a chained frame: replace without overrun.
    do_reset();
    run_frame(32'hCAFE0001, 1'b0, 1'b1, 100, 0, 1'b0, 1'b0, 1'b1, 32'hBEEF0002, lat);
    run_frame(32'hBEEF0002, 1'b0, 1'b0, 100, 0, 1'b0, 1'b1, 1'b0, '0, lat);
    check("pulse_q", 64'(Q), 64'(32'hBEEF0002));
    check("pulse_valid", 64'(VALID), 64'(1));
    check("pulse_overrun", 64'(OVERRUN), 64'(0));

    // Reset in the middle of a frame, then a fresh frame.
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h5A5A5A5A);
    repeat (17) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    do_reset();
    run_frame(32'h0000FFFF, 1'b0, 1'b1, 100, 0, 1'b0, 1'b0, 1'b0, '0, lat);
    check("post_rst_q", 64'(Q), 64'(32'h0000FFFF));
    check("post_rst_latency", 64'(lat), 64'(32));

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 8) != 0, ($urandom % 4) == 0, 1'($urandom),
           ($urandom % 3) != 0, W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
